// File: rtl/tolower_pkg.sv
// Shared constants, FSM state type and helpers for the streaming lowercase converter.
package tolower_pkg;

    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_Z = 8'h5A;
    localparam logic [7:0] CASE_BIT   = 8'h20;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_e;

    // True for 'A'..'Z' only; bytes with bit 7 set never match.
    function automatic logic is_upper(input logic [7:0] b);
        return (b >= ASCII_UC_A) && (b <= ASCII_UC_Z);
    endfunction

endpackage

// File: rtl/byte_skid_buf.sv
// Two-entry FIFO of {last, data} with a registered ready derived from next occupancy.
module byte_skid_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_data_i,
    input  logic       in_last_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic       out_last_o
);

    logic [8:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop;

    assign push        = in_valid_i & in_ready_q;
    assign pop         = (count_q != 2'd0) & out_ready_i;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q][7:0];
    assign out_last_o  = mem_q[rd_ptr_q][8];

    // Next occupancy; ready is registered from it so a full buffer is never written.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        in_ready_d = (count_d < 2'd2);
    end

    // Storage, pointers, occupancy and ready register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= 9'h000;
            mem_q[1]   <= 9'h000;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {in_last_i, in_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/tolower_stream.sv
// Streaming ASCII lowercase converter with output buffering and per-frame statistics.
module tolower_stream #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [7:0]       out_data_o,
    output logic             out_last_o,
    output logic             stat_valid_o,
    output logic [CNT_W-1:0] stat_count_o,
    output logic [CNT_W-1:0] stat_bytes_o
);
    import tolower_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_MAX) ? x : x + CNT_W'(1);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] frame_bytes_q, frame_bytes_d;
    logic [CNT_W-1:0] frame_conv_q, frame_conv_d;
    logic             stat_valid_q, stat_valid_d;
    logic [CNT_W-1:0] stat_count_q, stat_count_d;
    logic [CNT_W-1:0] stat_bytes_q, stat_bytes_d;
    logic             in_ready;
    logic             accept;
    logic             conv;
    logic [7:0]       conv_data;
    logic [CNT_W-1:0] bytes_inc, conv_inc;

    assign accept    = in_valid_i & in_ready;
    assign conv      = en_i & is_upper(in_data_i);
    assign conv_data = conv ? (in_data_i | CASE_BIT) : in_data_i;

    assign in_ready_o   = in_ready;
    assign stat_valid_o = stat_valid_q;
    assign stat_count_o = stat_count_q;
    assign stat_bytes_o = stat_bytes_q;

    byte_skid_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready),
        .in_data_i  (conv_data),
        .in_last_i  (in_last_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o)
    );

    // Frame FSM, saturating counters and statistics capture on the last byte.
    always_comb begin
        state_d       = state_q;
        frame_bytes_d = frame_bytes_q;
        frame_conv_d  = frame_conv_q;
        stat_valid_d  = 1'b0;
        stat_count_d  = stat_count_q;
        stat_bytes_d  = stat_bytes_q;
        bytes_inc     = sat_inc(frame_bytes_q);
        conv_inc      = conv ? sat_inc(frame_conv_q) : frame_conv_q;

        unique case (state_q)
            IDLE:     if (accept && !in_last_i) state_d = IN_FRAME;
            IN_FRAME: if (accept && in_last_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (accept) begin
            if (in_last_i) begin
                frame_bytes_d = '0;
                frame_conv_d  = '0;
                stat_valid_d  = 1'b1;
                stat_count_d  = conv_inc;
                stat_bytes_d  = bytes_inc;
            end else begin
                frame_bytes_d = bytes_inc;
                frame_conv_d  = conv_inc;
            end
        end
    end

    // State, counter and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frame_bytes_q <= '0;
            frame_conv_q  <= '0;
            stat_valid_q  <= 1'b0;
            stat_count_q  <= '0;
            stat_bytes_q  <= '0;
        end else begin
            state_q       <= state_d;
            frame_bytes_q <= frame_bytes_d;
            frame_conv_q  <= frame_conv_d;
            stat_valid_q  <= stat_valid_d;
            stat_count_q  <= stat_count_d;
            stat_bytes_q  <= stat_bytes_d;
        end
    end

endmodule

// File: tb/tb_tolower_stream.sv
// Scoreboard bench for tolower_stream: driver pushes expected bytes/stats, monitor pops and compares.
module tb_tolower_stream;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             stat_valid;
    logic [CNT_W-1:0] stat_count;
    logic [CNT_W-1:0] stat_bytes;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0]         exp_out_q[$];
    logic [2*CNT_W-1:0] exp_stat_q[$];

    logic [7:0] sb_in  [6] = '{8'h41, 8'h5A, 8'h40, 8'h5B, 8'h61, 8'hC1};
    logic [7:0] sb_exp [6] = '{8'h61, 8'h7A, 8'h40, 8'h5B, 8'h61, 8'hC1};
    logic [3:0] sb_cnt [6] = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [7:0] hello_in  [5] = '{8'h48, 8'h65, 8'h4C, 8'h4C, 8'h6F};
    logic [7:0] hello_exp [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    always #5 clk = ~clk;

    tolower_stream #(.CNT_W(CNT_W)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .stat_valid_o(stat_valid),
        .stat_count_o(stat_count),
        .stat_bytes_o(stat_bytes)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_stat(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] bytes);
        exp_stat_q.push_back({cnt, bytes});
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] d, input logic l, input logic e,
                        input logic [7:0] exp_d, input logic expect_out);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        en       = e;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else if (expect_out) begin
            exp_out_q.push_back({l, exp_d});
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_out_q.size() != 0 || exp_stat_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_queue_empty", exp_out_q.size(), 0);
        check("stat_queue_empty", exp_stat_q.size(), 0);
    endtask

    // Monitor: samples just before each rising edge, when driven inputs are settled.
    initial begin
        logic [8:0]         e_out;
        logic [2*CNT_W-1:0] e_stat;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (exp_out_q.size() == 0) begin
                        check("out_unexpected", {23'd0, out_last, out_data}, 32'h1FF);
                    end else begin
                        e_out = exp_out_q.pop_front();
                        check("out_byte", {23'd0, out_last, out_data}, {23'd0, e_out});
                    end
                end
                if (stat_valid) begin
                    if (exp_stat_q.size() == 0) begin
                        check("stat_unexpected", {31'd0, stat_valid}, 32'd0);
                    end else begin
                        e_stat = exp_stat_q.pop_front();
                        check("stat_count", 32'(stat_count), 32'(e_stat[2*CNT_W-1:CNT_W]));
                        check("stat_bytes", 32'(stat_bytes), 32'(e_stat[CNT_W-1:0]));
                    end
                end
            end
        end
    end

    initial begin
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_stat_valid", {31'd0, stat_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;

        // Single-byte frames
        for (int i = 0; i < 6; i++) begin
            expect_stat(sb_cnt[i], 4'd1);
            send(sb_in[i], 1'b1, 1'b1, sb_exp[i], 1'b1);
        end

        // "HeLLo"
        expect_stat(4'd3, 4'd5);
        for (int i = 0; i < 5; i++) begin
            send(hello_in[i], (i == 4), 1'b1, hello_exp[i], 1'b1);
        end
        drain();

        // Backpressure: out_ready low for 6 cycles while streaming 41,42,43
        out_ready = 1'b0;
        send(8'h41, 1'b0, 1'b1, 8'h61, 1'b1);
        send(8'h42, 1'b0, 1'b1, 8'h62, 1'b1);
        check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_out_data", {24'd0, out_data}, 32'h61);
        expect_stat(4'd3, 4'd3);
        fork
            send(8'h43, 1'b1, 1'b1, 8'h63, 1'b1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_hold_data", {24'd0, out_data}, 32'h61);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // en=0 frame, then en toggled per byte
        expect_stat(4'd0, 4'd2);
        send(8'h41, 1'b0, 1'b0, 8'h41, 1'b1);
        send(8'h42, 1'b1, 1'b0, 8'h42, 1'b1);
        expect_stat(4'd2, 4'd4);
        send(8'h41, 1'b0, 1'b1, 8'h61, 1'b1);
        send(8'h42, 1'b0, 1'b0, 8'h42, 1'b1);
        send(8'h43, 1'b0, 1'b1, 8'h63, 1'b1);
        send(8'h44, 1'b1, 1'b0, 8'h44, 1'b1);
        drain();

        // Saturation: 20 bytes with 4-bit counters
        expect_stat(4'd15, 4'd15);
        for (int i = 0; i < 20; i++) begin
            send(8'h41, (i == 19), 1'b1, 8'h61, 1'b1);
        end
        drain();

        // Reset mid-frame with two bytes still buffered
        send(8'h41, 1'b0, 1'b1, 8'h61, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h42, 1'b0, 1'b1, 8'h62, 1'b0);
        send(8'h43, 1'b0, 1'b1, 8'h63, 1'b0);
        check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_out_last", {31'd0, out_last}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_stat_count", 32'(stat_count), 32'd0);
        check("mid_rst_stat_bytes", 32'(stat_bytes), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        expect_stat(4'd1, 4'd1);
        send(8'h5A, 1'b1, 1'b1, 8'h7A, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
